// File: rtl/vbsme_pkg.sv
// Shared definitions for the variable block-size motion-estimation engine:
// block-mode encodings, block geometry lookup, FSM states and pipeline tags.
package vbsme_pkg;

  localparam int SAD_GUARD_W   = 8;
  localparam int DEFAULT_PIX_W = 8;
  localparam int DEFAULT_SAD_W = DEFAULT_PIX_W + SAD_GUARD_W;
  localparam int CAND_W        = 6;

  typedef enum logic [2:0] {
    MODE_4X4     = 3'd0,
    MODE_4X8     = 3'd1,
    MODE_8X4     = 3'd2,
    MODE_8X8     = 3'd3,
    MODE_8X16    = 3'd4,
    MODE_16X8    = 3'd5,
    MODE_16X16   = 3'd6,
    MODE_ILLEGAL = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WIN,
    SEARCH,
    DONE
  } state_e;

  typedef struct packed {
    logic [4:0] h;
    logic [4:0] w;
  } blk_dim_t;

  typedef struct packed {
    logic              firstCand;
    logic              finalCand;
    logic [CAND_W-1:0] candI;
    logic [CAND_W-1:0] candJ;
  } cand_tag_t;

  // Travels alongside each memory read so the returning pixel knows its role.
  typedef struct packed {
    logic      valid;
    logic      isWin;
    logic [7:0] idx;
    logic      firstPix;
    logic      lastPix;
    cand_tag_t cand;
  } mem_tag_t;

  function automatic blk_dim_t blockDims(input logic [2:0] mode);
    blk_dim_t d;
    case (mode)
      MODE_4X4:   d = '{h: 5'd4,  w: 5'd4};
      MODE_4X8:   d = '{h: 5'd4,  w: 5'd8};
      MODE_8X4:   d = '{h: 5'd8,  w: 5'd4};
      MODE_8X8:   d = '{h: 5'd8,  w: 5'd8};
      MODE_8X16:  d = '{h: 5'd8,  w: 5'd16};
      MODE_16X8:  d = '{h: 5'd16, w: 5'd8};
      MODE_16X16: d = '{h: 5'd16, w: 5'd16};
      default:    d = '{h: 5'd0,  w: 5'd0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vbsme_seq_engine_if.sv
// Control, memory-read and result signals of the motion-estimation engine.
// The master side requests searches and serves memory; the slave is the engine.
interface vbsme_seq_engine_if
  import vbsme_pkg::*;
#(
  parameter int FRAME_DIM = 64,
  parameter int PIX_W     = DEFAULT_PIX_W,
  parameter int SAD_W     = PIX_W + SAD_GUARD_W
);
  localparam int ADDR_W = $clog2(4 + FRAME_DIM * FRAME_DIM + 256);
  localparam int IDX_W  = $clog2(FRAME_DIM);

  logic              Start;
  logic [2:0]        Mode;
  logic [ADDR_W-1:0] MemAddr;
  logic [PIX_W-1:0]  MemData;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [IDX_W-1:0]  MinI;
  logic [IDX_W-1:0]  MinJ;
  logic [SAD_W-1:0]  MinVal;

  modport master (
    output Start, Mode, MemData,
    input  MemAddr, Busy, Done, Err, MinI, MinJ, MinVal
  );

  modport slave (
    input  Start, Mode, MemData,
    output MemAddr, Busy, Done, Err, MinI, MinJ, MinVal
  );

endinterface

// File: rtl/vbsme_seq_engine_sad_accumulator.sv
// Absolute-difference accumulator: clr restarts the sum with the current
// difference, otherwise the difference is added; one result per cycle.
module sad_accumulator
  import vbsme_pkg::*;
#(
  parameter int PIX_W = DEFAULT_PIX_W,
  parameter int SAD_W = DEFAULT_SAD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [SAD_W-1:0] acc
);

  logic [PIX_W-1:0] absDiff;

  assign absDiff = (a >= b) ? (a - b) : (b - a);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? SAD_W'(absDiff) : acc + SAD_W'(absDiff);
    end
  end

endmodule

// File: rtl/vbsme_seq_engine.sv
// Full-search block matcher: loads the reference window, then streams every
// candidate block of the frame through a SAD accumulator and keeps the minimum.
module vbsme_seq_engine
  import vbsme_pkg::*;
#(
  parameter int FRAME_DIM = 64,
  parameter int PIX_W     = DEFAULT_PIX_W,
  parameter int SAD_W     = PIX_W + SAD_GUARD_W
) (
  input logic               Clk,
  input logic               Reset,
  vbsme_seq_engine_if.slave bus
);

  localparam int ADDR_W   = $clog2(4 + FRAME_DIM * FRAME_DIM + 256);
  localparam int IDX_W    = $clog2(FRAME_DIM);
  localparam int WIN_BASE = 4 + FRAME_DIM * FRAME_DIM;

  state_e            state;
  logic [2:0]        modeReg;
  blk_dim_t          dims;
  logic [8:0]        blkArea;
  logic [7:0]        lastPixIdx;
  logic [3:0]        lastPixC;
  logic [CAND_W-1:0] lastCandI;
  logic [CAND_W-1:0] lastCandJ;
  logic [7:0]        pixIdx;
  logic [3:0]        pixR;
  logic [3:0]        pixC;
  logic [CAND_W-1:0] candI;
  logic [CAND_W-1:0] candJ;
  logic              issueDone;
  logic [ADDR_W-1:0] frameAddr;
  logic [ADDR_W-1:0] winAddr;
  mem_tag_t          issueTag;
  mem_tag_t          tag1;
  mem_tag_t          tag2;
  logic              resValid;
  cand_tag_t         resCand;
  logic [PIX_W-1:0]  winReg [256];
  logic [SAD_W-1:0]  accVal;
  logic [SAD_W-1:0]  bestVal;
  logic [CAND_W-1:0] bestI;
  logic [CAND_W-1:0] bestJ;
  logic              candBetter;

  assign dims       = blockDims(modeReg);
  assign blkArea    = 9'(dims.h) * 9'(dims.w);
  assign lastPixIdx = 8'(blkArea - 9'd1);
  assign lastPixC   = 4'(dims.w - 5'd1);
  assign lastCandI  = CAND_W'(FRAME_DIM - int'(dims.h));
  assign lastCandJ  = CAND_W'(FRAME_DIM - int'(dims.w));
  assign winAddr    = ADDR_W'(WIN_BASE + int'(pixIdx));
  assign frameAddr  = ADDR_W'(4 + (int'(candI) + int'(pixR)) * FRAME_DIM
                              + int'(candJ) + int'(pixC));
  assign candBetter = resCand.firstCand || (accVal < bestVal);

  always_comb begin
    issueTag                = '0;
    issueTag.idx            = pixIdx;
    issueTag.firstPix       = (pixIdx == 8'd0);
    issueTag.lastPix        = (pixIdx == lastPixIdx);
    issueTag.cand.firstCand = (candI == '0) && (candJ == '0);
    issueTag.cand.finalCand = (candI == lastCandI) && (candJ == lastCandJ);
    issueTag.cand.candI     = candI;
    issueTag.cand.candJ     = candJ;
  end

  always_ff @(posedge Clk) begin
    if (tag2.valid && tag2.isWin) begin
      winReg[tag2.idx] <= bus.MemData;
    end
  end

  sad_accumulator #(
    .PIX_W (PIX_W),
    .SAD_W (SAD_W)
  ) u_sad (
    .clk   (Clk),
    .reset (Reset),
    .en    (tag2.valid && !tag2.isWin),
    .clr   (tag2.firstPix),
    .a     (bus.MemData),
    .b     (winReg[tag2.idx]),
    .acc   (accVal)
  );

  // Read data returns one cycle after its address, and the sum one cycle after
  // that, so tags trail MemAddr by two stages before the minimum is judged.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      modeReg     <= '0;
      bus.Busy    <= 1'b0;
      bus.Done    <= 1'b0;
      bus.Err     <= 1'b0;
      bus.MinI    <= '0;
      bus.MinJ    <= '0;
      bus.MinVal  <= '0;
      bus.MemAddr <= '0;
      pixIdx      <= '0;
      pixR        <= '0;
      pixC        <= '0;
      candI       <= '0;
      candJ       <= '0;
      issueDone   <= 1'b0;
      tag1        <= '0;
      tag2        <= '0;
      resValid    <= 1'b0;
      resCand     <= '0;
      bestVal     <= '0;
      bestI       <= '0;
      bestJ       <= '0;
    end else begin
      tag1.valid <= 1'b0;
      tag2       <= tag1;
      resValid   <= tag2.valid && !tag2.isWin && tag2.lastPix;
      resCand    <= tag2.cand;

      if (resValid && candBetter) begin
        bestVal <= accVal;
        bestI   <= resCand.candI;
        bestJ   <= resCand.candJ;
      end

      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            if (bus.Mode == MODE_ILLEGAL) begin
              state      <= DONE;
              bus.Done   <= 1'b1;
              bus.Err    <= 1'b1;
              bus.MinI   <= '0;
              bus.MinJ   <= '0;
              bus.MinVal <= '1;
            end else begin
              state       <= LOAD_WIN;
              modeReg     <= bus.Mode;
              bus.Busy    <= 1'b1;
              bus.Done    <= 1'b0;
              bus.Err     <= 1'b0;
              bus.MemAddr <= ADDR_W'(WIN_BASE);
              tag1        <= '0;
              tag1.valid  <= 1'b1;
              tag1.isWin  <= 1'b1;
              pixIdx      <= 8'd1;
            end
          end
        end

        LOAD_WIN: begin
          bus.MemAddr <= winAddr;
          tag1        <= issueTag;
          tag1.valid  <= 1'b1;
          tag1.isWin  <= 1'b1;
          if (pixIdx == lastPixIdx) begin
            state     <= SEARCH;
            pixIdx    <= '0;
            pixR      <= '0;
            pixC      <= '0;
            candI     <= '0;
            candJ     <= '0;
            issueDone <= 1'b0;
          end else begin
            pixIdx <= pixIdx + 8'd1;
          end
        end

        SEARCH: begin
          if (!issueDone) begin
            bus.MemAddr <= frameAddr;
            tag1        <= issueTag;
            tag1.valid  <= 1'b1;
            if (pixIdx == lastPixIdx) begin
              pixIdx <= '0;
              pixR   <= '0;
              pixC   <= '0;
              if (candJ == lastCandJ) begin
                candJ <= '0;
                if (candI == lastCandI) begin
                  issueDone <= 1'b1;
                end else begin
                  candI <= candI + CAND_W'(1);
                end
              end else begin
                candJ <= candJ + CAND_W'(1);
              end
            end else begin
              pixIdx <= pixIdx + 8'd1;
              if (pixC == lastPixC) begin
                pixC <= '0;
                pixR <= pixR + 4'd1;
              end else begin
                pixC <= pixC + 4'd1;
              end
            end
          end
          if (resValid && resCand.finalCand) begin
            state      <= DONE;
            bus.Busy   <= 1'b0;
            bus.Done   <= 1'b1;
            bus.MinVal <= candBetter ? accVal : bestVal;
            bus.MinI   <= IDX_W'(candBetter ? resCand.candI : bestI);
            bus.MinJ   <= IDX_W'(candBetter ? resCand.candJ : bestJ);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vbsme_seq_engine.sv
// Self-checking bench for vbsme_seq_engine on a 16x16 frame with a 1-cycle memory;
// expected results come from an exhaustive search over the memory image.
module tb_vbsme_seq_engine;

  localparam int FD       = 16;
  localparam int PIX_W    = 8;
  localparam int SAD_W    = 16;
  localparam int IDX_W    = 4;
  localparam int ADDR_W   = 10;
  localparam int WIN_BASE = 4 + FD * FD;
  localparam int LIMIT    = 8000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [1024];
  int   hTab [7] = '{4, 4, 8, 8, 8, 16, 16};
  int   wTab [7] = '{4, 8, 4, 8, 16, 8, 16};

  vbsme_seq_engine_if #(.FRAME_DIM(FD), .PIX_W(PIX_W), .SAD_W(SAD_W)) bus ();

  vbsme_seq_engine #(
    .FRAME_DIM (FD),
    .PIX_W     (PIX_W),
    .SAD_W     (SAD_W)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.MemData <= mem[bus.MemAddr];

  function automatic int expLatency(input int mode);
    int h, w;
    h = hTab[mode];
    w = wTab[mode];
    return h * w + (FD - h + 1) * (FD - w + 1) * h * w + 2;
  endfunction

  // Exhaustive row-major search; a later candidate wins only on a strictly smaller SAD.
  task automatic refModel(input int mode, output int bi, output int bj, output int bv);
    int h, w, s, d;
    h = hTab[mode];
    w = wTab[mode];
    bv = -1; bi = 0; bj = 0;
    for (int i = 0; i <= FD - h; i++) begin
      for (int j = 0; j <= FD - w; j++) begin
        s = 0;
        for (int r = 0; r < h; r++) begin
          for (int c = 0; c < w; c++) begin
            d = int'(mem[4 + (i + r) * FD + j + c]) - int'(mem[WIN_BASE + r * w + c]);
            s += (d < 0) ? -d : d;
          end
        end
        if (bv < 0 || s < bv) begin
          bv = s; bi = i; bj = j;
        end
      end
    end
  endtask

  task automatic fillRegion(input int base, input int count, input int lo, input int hi);
    for (int k = 0; k < count; k++) mem[base + k] = 8'($urandom_range(lo, hi));
  endtask

  task automatic startSearch(input int mode);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Mode  = 3'(mode);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output bit timedOut, output bit busyLow,
                          output bit moved);
    logic [IDX_W-1:0] i0, j0;
    logic [SAD_W-1:0] v0;
    i0 = bus.MinI; j0 = bus.MinJ; v0 = bus.MinVal;
    cycles = 0; timedOut = 0; busyLow = 0; moved = 0;
    while (bus.Done !== 1'b1 && cycles < LIMIT) begin
      if (bus.Busy !== 1'b1) busyLow = 1;
      if (bus.MinI !== i0 || bus.MinJ !== j0 || bus.MinVal !== v0) moved = 1;
      @(posedge clk);
      #1;
      cycles++;
    end
    timedOut = (bus.Done !== 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.Start = 1'b0; bus.Mode = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.Err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got %b want 000", {bus.Busy, bus.Done, bus.Err});
    end
    checks++;
    if (bus.MinI !== '0 || bus.MinJ !== '0 || bus.MinVal !== '0 || bus.MemAddr !== '0) begin
      errors++; $display("[TB] FAIL reset_values got I=%0d J=%0d V=%0d A=%0d want 0", bus.MinI, bus.MinJ, bus.MinVal, bus.MemAddr);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_uniform();
    int cyc; bit tmo, bl, mv;
    fillRegion(4, 256, 8'h10, 8'h10);
    fillRegion(WIN_BASE, 256, 8'h10, 8'h10);
    startSearch(0);
    waitDone(cyc, tmo, bl, mv);
    checks++;
    if (tmo || cyc != 2722) begin
      errors++; $display("[TB] FAIL uniform_latency got %0d (timeout=%0d) want 2722", cyc, tmo);
    end
    checks++;
    if (bus.MinI !== 4'd0 || bus.MinJ !== 4'd0 || bus.MinVal !== 16'd0) begin
      errors++; $display("[TB] FAIL uniform_result got %0d,%0d,%0d want 0,0,0", bus.MinI, bus.MinJ, bus.MinVal);
    end
    checks++;
    if (bl || bus.Busy !== 1'b0 || bus.Err !== 1'b0) begin
      errors++; $display("[TB] FAIL uniform_busy got gap=%0d busy=%b err=%b want 0,0,0", bl, bus.Busy, bus.Err);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.Done !== 1'b1 || bus.MinVal !== 16'd0) begin
      errors++; $display("[TB] FAIL done_hold got done=%b val=%0d want 1,0", bus.Done, bus.MinVal);
    end
  endtask

  task automatic test_illegal();
    bit busySeen;
    startSearch(7);
    checks++;
    if (bus.Done !== 1'b1 || bus.Err !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_flags got done=%b err=%b busy=%b want 1,1,0", bus.Done, bus.Err, bus.Busy);
    end
    checks++;
    if (bus.MinVal !== 16'hFFFF || bus.MinI !== 4'd0 || bus.MinJ !== 4'd0) begin
      errors++; $display("[TB] FAIL illegal_result got %0d,%0d,%h want 0,0,ffff", bus.MinI, bus.MinJ, bus.MinVal);
    end
    busySeen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.Busy !== 1'b0) busySeen = 1;
    end
    checks++;
    if (busySeen) begin
      errors++; $display("[TB] FAIL illegal_busy got busy asserted want never");
    end
  endtask

  task automatic test_patch();
    int cyc; bit tmo, bl, mv;
    fillRegion(4, 256, 0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mem[4 + (9 + r) * FD + 5 + c] = 8'hFF;
    fillRegion(WIN_BASE, 256, 8'hFF, 8'hFF);
    startSearch(0);
    checks++;
    if (bus.Done !== 1'b0 || bus.Err !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++; $display("[TB] FAIL restart_from_done got done=%b err=%b busy=%b want 0,0,1", bus.Done, bus.Err, bus.Busy);
    end
    waitDone(cyc, tmo, bl, mv);
    checks++;
    if (tmo || cyc != 2722) begin
      errors++; $display("[TB] FAIL patch_latency got %0d want 2722", cyc);
    end
    checks++;
    if (bus.MinI !== 4'd9 || bus.MinJ !== 4'd5 || bus.MinVal !== 16'd0) begin
      errors++; $display("[TB] FAIL patch_result got %0d,%0d,%0d want 9,5,0", bus.MinI, bus.MinJ, bus.MinVal);
    end
    checks++;
    if (mv) begin
      errors++; $display("[TB] FAIL patch_result_stable got early change want none before Done");
    end
  endtask

  task automatic test_full_block();
    int cyc; bit tmo, bl, mv;
    fillRegion(4, 256, 0, 0);
    fillRegion(WIN_BASE, 256, 3, 3);
    startSearch(6);
    waitDone(cyc, tmo, bl, mv);
    checks++;
    if (tmo || cyc != 514) begin
      errors++; $display("[TB] FAIL full_latency got %0d want 514", cyc);
    end
    checks++;
    if (bus.MinI !== 4'd0 || bus.MinJ !== 4'd0 || bus.MinVal !== 16'd768) begin
      errors++; $display("[TB] FAIL full_result got %0d,%0d,%0d want 0,0,768", bus.MinI, bus.MinJ, bus.MinVal);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, ei, ej, ev, doneSeen; bit tmo, bl, mv;
    fillRegion(4, 256, 0, 255);
    fillRegion(WIN_BASE, 256, 0, 255);
    refModel(3, ei, ej, ev);
    startSearch(3);
    repeat (300) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; bus.Start = 1'b1; bus.Mode = 3'd3;
    @(posedge clk);
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.MinVal !== '0 || bus.MemAddr !== '0) begin
      errors++; $display("[TB] FAIL abort_reset got busy=%b done=%b val=%0d addr=%0d want 0", bus.Busy, bus.Done, bus.MinVal, bus.MemAddr);
    end
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) doneSeen++;
    end
    checks++;
    if (doneSeen != 0) begin
      errors++; $display("[TB] FAIL abort_idle got %0d active samples want 0", doneSeen);
    end
    startSearch(3);
    waitDone(cyc, tmo, bl, mv);
    checks++;
    if (tmo || cyc != expLatency(3)) begin
      errors++; $display("[TB] FAIL abort_latency got %0d want %0d", cyc, expLatency(3));
    end
    checks++;
    if (int'(bus.MinI) != ei || int'(bus.MinJ) != ej || int'(bus.MinVal) != ev) begin
      errors++; $display("[TB] FAIL abort_result got %0d,%0d,%0d want %0d,%0d,%0d", bus.MinI, bus.MinJ, bus.MinVal, ei, ej, ev);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, ei, ej, ev;
    fillRegion(4, 256, 0, 7);
    fillRegion(WIN_BASE, 256, 0, 7);
    refModel(0, ei, ej, ev);
    startSearch(0);
    cyc = 0;
    while (bus.Done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      bus.Start = ($urandom_range(0, 9) == 0);
      bus.Mode  = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.Start = 1'b0;
    checks++;
    if (bus.Done !== 1'b1 || cyc != expLatency(0)) begin
      errors++; $display("[TB] FAIL busy_latency got %0d want %0d", cyc, expLatency(0));
    end
    checks++;
    if (int'(bus.MinI) != ei || int'(bus.MinJ) != ej || int'(bus.MinVal) != ev) begin
      errors++; $display("[TB] FAIL busy_result got %0d,%0d,%0d want %0d,%0d,%0d", bus.MinI, bus.MinJ, bus.MinVal, ei, ej, ev);
    end
  endtask

  task automatic test_random();
    int mode, cyc, ei, ej, ev; bit tmo, bl, mv;
    for (int n = 0; n < 3; n++) begin
      mode = $urandom_range(0, 6);
      fillRegion(4, 256, 0, 3);
      fillRegion(WIN_BASE, 256, 0, 3);
      refModel(mode, ei, ej, ev);
      startSearch(mode);
      waitDone(cyc, tmo, bl, mv);
      checks++;
      if (tmo || cyc != expLatency(mode)) begin
        errors++; $display("[TB] FAIL rand_latency mode %0d got %0d want %0d", mode, cyc, expLatency(mode));
      end
      checks++;
      if (int'(bus.MinI) != ei || int'(bus.MinJ) != ej || int'(bus.MinVal) != ev) begin
        errors++; $display("[TB] FAIL rand_result mode %0d got %0d,%0d,%0d want %0d,%0d,%0d", mode, bus.MinI, bus.MinJ, bus.MinVal, ei, ej, ev);
      end
      checks++;
      if (bl || mv || bus.Busy !== 1'b0) begin
        errors++; $display("[TB] FAIL rand_status mode %0d got gap=%0d moved=%0d busy=%b want 0,0,0", mode, bl, mv, bus.Busy);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
    test_reset();
    test_uniform();
    test_illegal();
    test_patch();
    test_full_block();
    test_reset_abort();
    test_busy_ignore();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vbsme_seq_engine.md
VBSME_SEQ_ENGINE -- requirements
Module: vbsme_seq_engine

Interface
REQ-001 SHALL have parameter FRAME_DIM, default 64, meaning square frame side in pixels (legal 16..64).
REQ-002 SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-003 SHALL have parameter SAD_W, default PIX_W+8, meaning accumulator/result width, sized for a 16x16 block.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: Clk in 1, rising-edge clock; Reset in 1, synchronous active-high reset.
REQ-005 SHALL have Start in 1, one-cycle request to begin a search.
REQ-006 SHALL have Mode in 3, block size: 0=4x4, 1=4x8, 2=8x4, 3=8x8, 4=8x16, 5=16x8, 6=16x16 (HxW); 7=illegal.
REQ-007 SHALL have MemAddr out clog2(4+FRAME_DIM^2+256), read address to external pixel memory.
REQ-008 SHALL have MemData in PIX_W, read data, valid exactly one cycle after MemAddr.
REQ-009 SHALL have Busy out 1, Done out 1, Err out 1.
REQ-010 SHALL have MinI out clog2(FRAME_DIM), MinJ out clog2(FRAME_DIM), MinVal out SAD_W: best row, column, SAD.

Function
REQ-011 SHALL address frame pixel (r,c) at 4+r*FRAME_DIM+c and window pixel (r,c) at 4+FRAME_DIM^2+r*W+c.
REQ-012 SHALL implement states IDLE, LOAD_WIN, SEARCH, DONE.
REQ-013 IDLE: Start=1 with legal Mode SHALL latch Mode, clear Done, set Busy, go to LOAD_WIN next cycle.
REQ-014 IDLE or DONE: Start=1 with Mode=7 SHALL go to DONE next cycle with Err=1, MinI=MinJ=0, MinVal=all ones.
REQ-015 LOAD_WIN SHALL issue H*W window reads, one per cycle, row-major, into an internal 16x16 register array, then enter SEARCH.
REQ-016 SEARCH SHALL visit candidates (i,j), i in 0..FRAME_DIM-H, j in 0..FRAME_DIM-W, row-major, issuing one frame read per cycle with no bubbles between candidates.
REQ-017 Per candidate SHALL accumulate |frame-window| over H*W pixels at SAD_W width without saturation.
REQ-018 On each candidate's last accumulation SHALL update minimum only if SAD < current MinVal (strict); ties keep the earlier candidate; the first candidate always loads.
REQ-019 Done SHALL rise exactly W*H + (FRAME_DIM-H+1)*(FRAME_DIM-W+1)*W*H + 2 cycles after the Start cycle; Busy falls the same cycle.
REQ-020 DONE SHALL hold Done and results stable until the next Start; Start in DONE behaves as in IDLE (clears Done the next cycle).
REQ-021 Start while Busy SHALL be ignored; Mode changes while Busy SHALL have no effect.
REQ-022 MinI/MinJ/MinVal SHALL change only at DONE entry; intermediate minimum is kept in internal registers.

Reset
REQ-023 Reset SHALL force IDLE, Busy=0, Done=0, Err=0, MinI=0, MinJ=0, MinVal=0, MemAddr=0, clear accumulator, regardless of state.
REQ-024 Reset asserted mid-search SHALL abort without producing Done; a Start after Reset deasserts SHALL run a full fresh search.
REQ-025 Reset SHALL take priority over a simultaneous Start.

Structure
REQ-026 A shared package vbsme_pkg SHALL hold the Mode encodings, H/W lookup function, state enum and SAD_W default.
REQ-027 One sub-module sad_accumulator (absolute difference plus clear/accumulate register, one cycle) SHALL be instantiated.

Verification (bench uses FRAME_DIM=16, behavioural memory with 1-cycle latency)
REQ-028 Frame all 0x10, window all 0x10, Mode=0 -> Done at cycle 16+169*16+2=2722, MinI=0, MinJ=0, MinVal=0.
REQ-029 Frame all 0x00 except 4x4 patch 0xFF at (9,5); window all 0xFF, Mode=0 -> MinI=9, MinJ=5, MinVal=0.
REQ-030 Frame all 0x00, window all 0x03, Mode=6 -> single candidate, MinI=0, MinJ=0, MinVal=768, Done 2*256+2 cycles after Start.
REQ-031 Mode=7 Start -> next cycle Done=1, Err=1, MinVal=all ones; Busy never asserts.
REQ-032 Reset mid-SEARCH, then Start with Mode=3 -> no Done before restart; results match a clean run.
REQ-033 Start pulses while Busy with Mode toggling -> ignored; Done timing and results match the original Mode.
